fb_write_sched: RTL
===================

# fb_write_sched

Frame-granular write scheduler for the SDRAM frame buffer. It arbitrates between two pixel sources, source 0 (test-pattern generator) and source 1 (video input), for the single SDRAM write-FIFO port, and grants one whole frame at a time. It double-buffers the SDRAM frame store: the writer fills the back bank while the LCD read path scans the front bank, and the banks swap on the next LCD vertical sync after a frame completes. It sits between the pixel sources and the SDRAM controller's write FIFO, and drives the bank selects used by the SDRAM controller.

## Interface
Parameters:
- FIFO_WIDTH, 16, write-FIFO data width.
- FRAME_LEN, LCD_IN_H_DISP*LCD_IN_V_DISP, pixels per frame.
- CNT_W, 20, beat-counter width; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk_50m  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- sdram_init_done  in  1  SDRAM ready; arbitration is blocked while low.
- req0, req1  in  1  frame request from source 0 / source 1, level-sensitive.
- src0_data, src1_data  in  FIFO_WIDTH  pixel data.
- src0_valid, src1_valid  in  1  pixel valid.
- src0_ready, src1_ready  out  1  pixel accepted this cycle.
- wr_full  in  1  write-FIFO almost-full; stalls transfers.
- wr_en  out  1  write-FIFO write enable.
- wr_data  out  FIFO_WIDTH  write-FIFO data.
- wr_bank  out  1  SDRAM bank being written.
- rd_bank  out  1  SDRAM bank scanned by the LCD.
- lcd_vs  in  1  LCD vsync, asynchronous (lcd_pclk domain), active-high pulse.
- grant  out  2  one-hot current owner; 00 = none.
- frame_done  out  1  one-cycle pulse when the bank swap occurs.

## Operation
FSM states: IDLE, XFER, SWAP_WAIT.
- IDLE: if sdram_init_done and (req0 or req1), grant round-robin.
  - Both requests active: grant the source not granted last.
  - last_grant resets to 1, so source 0 wins the first tie.
  - On grant, clear the beat counter and go to XFER.
- XFER: srcN_ready = grant[N] & ~wr_full; the non-granted ready is 0.
  - A beat is srcN_valid & srcN_ready. Each beat increments the counter.
  - req changes during XFER are ignored. A granted frame always completes with FRAME_LEN beats.
  - The beat that brings the count to FRAME_LEN moves the FSM to SWAP_WAIT. Ready deasserts in the same cycle.
- SWAP_WAIT: no ready asserted. Wait for a synchronized lcd_vs rising edge.
  - On the edge: rd_bank <= wr_bank, wr_bank <= ~wr_bank, frame_done = 1, grant <= 00, return to IDLE.
- lcd_vs edges seen in IDLE or XFER are discarded, not latched. An edge in the cycle the FSM enters SWAP_WAIT is also discarded.
- sdram_init_done falling in XFER or SWAP_WAIT does not abort the current frame. It only blocks the next grant.
- Counter arithmetic is unsigned CNT_W. The comparison is count == FRAME_LEN-1 on a beat, so the counter never wraps.

## Timing
- Reset values:
  - wr_en = 0, wr_data = 0.
  - src*_ready = 0, grant = 00, frame_done = 0.
  - wr_bank = 1, rd_bank = 0.
  - FSM = IDLE, last_grant = 1, counter = 0.
- Reset may assert mid-frame. All state returns to the reset values at once; the partial frame is abandoned.
- Grant latency: req sampled in IDLE → grant and FSM = XFER on the next edge. src_ready can assert in the first XFER cycle.
- Write latency: a beat in cycle t → wr_en = 1 and wr_data = the beat's data in cycle t+1 (registered). No beat → wr_en = 0 and wr_data = 0.
- src_ready is combinational from state, grant and wr_full. There is no skid buffer; the FIFO almost-full margin must be at least 2 entries.
- lcd_vs path: 2-flop synchronizer, then a rising-edge detect. Swap latency is 3 clk_50m cycles from the asynchronous edge, ±1.
- frame_done, the bank update and grant = 00 all occur in the same cycle.

## Structure
- FIFO_WIDTH, FRAME_LEN and the FSM state encodings belong in the shared LCD/SDRAM timing header.
- Sub-module vs_sync: 2-FF synchronizer plus rising-edge pulse on lcd_vs, reset to 0. It is reusable for lcd_hs.
- Everything else lives in fb_write_sched.

## Test plan
Run with FRAME_LEN = 16.
- Reset, sdram_init_done = 1, req0 = 1, src0_valid held high → 16 wr_en pulses of src0_data, starting 1 cycle after the first ready. FSM enters SWAP_WAIT, and src0_ready = 0 afterwards.
- Continue the first test, then pulse lcd_vs → frame_done pulse ~3 cycles later. wr_bank goes 1→0 and rd_bank goes 0→1.
- req0 = req1 = 1 for 3 frames → grants src0, src1, src0. Each frame is 16 beats and each is followed by a swap.
- wr_full toggled every 3 cycles and src0_valid randomly gapped → exactly 16 wr_en pulses, in order, with no beat while wr_full = 1.
- lcd_vs pulsed during XFER → no swap. The swap happens only on the first lcd_vs after frame completion.
- rst_n asserted after 7 beats → all outputs at reset values immediately. A fresh req0 afterwards transfers a full 16 beats.

Source files
------------

// File: rtl/fb_write_sched_pkg.sv
// Shared LCD/SDRAM frame-buffer constants and write-scheduler state encoding.
package fb_write_sched_pkg;

    localparam int unsigned LCD_IN_H_DISP  = 800;
    localparam int unsigned LCD_IN_V_DISP  = 480;
    localparam int unsigned LCD_FIFO_WIDTH = 16;
    localparam int unsigned LCD_FRAME_LEN  = LCD_IN_H_DISP * LCD_IN_V_DISP;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StXfer     = 2'd1,
        StSwapWait = 2'd2
    } sched_state_e;

    // Round-robin pick: on a tie the source not granted last wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
        if (req0 && req1) begin
            return ~last_grant;
        end
        return req0 ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/fb_write_sched_if.sv
// Pixel-source / write-FIFO / bank-select bundle between the sources and the write scheduler.
interface fb_write_sched_if
    import fb_write_sched_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = LCD_FIFO_WIDTH
);

    logic                  req0;
    logic                  req1;
    logic [FIFO_WIDTH-1:0] src0_data;
    logic [FIFO_WIDTH-1:0] src1_data;
    logic                  src0_valid;
    logic                  src1_valid;
    logic                  src0_ready;
    logic                  src1_ready;
    logic                  wr_full;
    logic                  wr_en;
    logic [FIFO_WIDTH-1:0] wr_data;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [1:0]            grant;
    logic                  frame_done;

    // Source / FIFO side.
    modport master (
        output req0, req1, src0_data, src1_data, src0_valid, src1_valid, wr_full,
        input  src0_ready, src1_ready, wr_en, wr_data, wr_bank, rd_bank, grant, frame_done
    );

    // Scheduler side.
    modport slave (
        input  req0, req1, src0_data, src1_data, src0_valid, src1_valid, wr_full,
        output src0_ready, src1_ready, wr_en, wr_data, wr_bank, rd_bank, grant, frame_done
    );

endinterface

// File: rtl/fb_write_sched_vs_sync.sv
// Two-flop synchronizer followed by a one-cycle rising-edge pulse; reusable for lcd_hs too.
module fb_write_sched_vs_sync (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/fb_write_sched.sv
// Frame-granular round-robin write scheduler with double-buffered SDRAM bank swap on LCD vsync.
module fb_write_sched
    import fb_write_sched_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = LCD_FIFO_WIDTH,
    parameter int unsigned FRAME_LEN  = LCD_FRAME_LEN,
    parameter int unsigned CNT_W      = 20
) (
    input  logic            clk_50m,
    input  logic            rst_n,
    input  logic            sdram_init_done,
    input  logic            lcd_vs,
    fb_write_sched_if.slave bus
);

    sched_state_e          state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  frame_done_q, frame_done_d;

    logic                  vs_rise;
    logic                  in_xfer;
    logic                  src0_ready;
    logic                  src1_ready;
    logic                  beat;
    logic                  pick;
    logic [FIFO_WIDTH-1:0] beat_data;

    fb_write_sched_vs_sync u_vs_sync (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .async_in (lcd_vs),
        .rise     (vs_rise)
    );

    // No skid buffer: ready follows wr_full directly, so the FIFO needs >= 2 entries of margin.
    assign in_xfer    = (state_q == StXfer);
    assign src0_ready = in_xfer & grant_q[0] & ~bus.wr_full;
    assign src1_ready = in_xfer & grant_q[1] & ~bus.wr_full;
    assign beat       = (src0_ready & bus.src0_valid) | (src1_ready & bus.src1_valid);
    assign beat_data  = grant_q[1] ? bus.src1_data : bus.src0_data;
    assign pick       = rr_pick(bus.req0, bus.req1, last_grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        frame_done_d = 1'b0;
        wr_en_d      = beat;
        wr_data_d    = beat ? beat_data : '0;

        case (state_q)
            StIdle: begin
                if (sdram_init_done && (bus.req0 || bus.req1)) begin
                    grant_d      = pick ? 2'b10 : 2'b01;
                    last_grant_d = pick;
                    cnt_d        = '0;
                    state_d      = StXfer;
                end
            end
            StXfer: begin
                if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        state_d = StSwapWait;
                    end
                end
            end
            StSwapWait: begin
                // Edges outside this state are dropped, never latched.
                if (vs_rise) begin
                    rd_bank_d    = wr_bank_q;
                    wr_bank_d    = ~wr_bank_q;
                    frame_done_d = 1'b1;
                    grant_d      = 2'b00;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            wr_bank_q    <= 1'b1;
            rd_bank_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.src0_ready = src0_ready;
    assign bus.src1_ready = src1_ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_bank    = wr_bank_q;
    assign bus.rd_bank    = rd_bank_q;
    assign bus.grant      = grant_q;
    assign bus.frame_done = frame_done_q;

endmodule
